// File: rtl/hex_scan_pkg.sv
// Shared constants for the hex digit scanner.
// Optional leading-zero blanking is selected with `define HEX_SCAN_LZB_EN.
package hex_scan_pkg;

   localparam int DEF_NUM_DIGITS = 4;
   localparam int DEF_PRESCALE   = 50000;
   localparam int MAX_DIGITS     = 8;

   // Sliced down to NUM_DIGITS bits at the point of use.
   localparam logic [MAX_DIGITS-1:0] SEL_OFF = '1;

   localparam logic [3:0] BLANK_NIBBLE = 4'h0;

   localparam logic [3:0] RST_BINARY    = 4'h0;
   localparam logic       RST_ENABLE    = 1'b0;
   localparam logic       RST_SCAN_TICK = 1'b0;

endpackage

// File: rtl/hex_digit_scan_if.sv
// Display-side bundle of the hex digit scanner: value/strobe in, decoder and digit drive out.
interface hex_digit_scan_if #(
   parameter int NUM_DIGITS = hex_scan_pkg::DEF_NUM_DIGITS
);

   logic [4*NUM_DIGITS-1:0] value;
   logic                    load;
   logic                    display_on;
   logic [3:0]              binary;
   logic                    enable;
   logic [NUM_DIGITS-1:0]   digit_sel_n;
   logic                    scan_tick;

   modport master (
      output value, load, display_on,
      input  binary, enable, digit_sel_n, scan_tick
   );

   modport slave (
      input  value, load, display_on,
      output binary, enable, digit_sel_n, scan_tick
   );

endinterface

// File: rtl/scan_prescaler.sv
// Dwell counter: counts 0..PRESCALE-1 and flags the guard cycle and the dwell boundary.
module scan_prescaler
   import hex_scan_pkg::*;
#(
   parameter int PRESCALE = DEF_PRESCALE
) (
   input  logic clk,
   input  logic rst,
   output logic pcnt_zero,
   output logic wrap
);

   localparam int                PCNT_W = $clog2(PRESCALE);
   localparam logic [PCNT_W-1:0] LAST   = PCNT_W'(PRESCALE - 1);

   logic [PCNT_W-1:0] pcnt;

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst)       pcnt <= '0;
      else if (wrap) pcnt <= '0;
      else           pcnt <= pcnt + 1'b1;
   end

   assign pcnt_zero = (pcnt == '0);
   assign wrap      = (pcnt == LAST);

endmodule

// File: rtl/hex_digit_scan.sv
// Time-multiplexed scanner for a common-anode seven-segment display (one shared decoder).
// Define HEX_SCAN_LZB_EN to blank leading zero digits.
module hex_digit_scan
   import hex_scan_pkg::*;
#(
   parameter int NUM_DIGITS = DEF_NUM_DIGITS,
   parameter int PRESCALE   = DEF_PRESCALE
) (
   input  logic             clk,
   input  logic             rst,
   hex_digit_scan_if.slave  bus
);

   localparam int               IDX_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_DIGITS - 1);

   logic [4*NUM_DIGITS-1:0] shadow;
   logic [IDX_W-1:0]        idx;
   logic                    pcnt_zero;
   logic                    wrap;

   logic                    digit_ok;
   logic                    show;
   logic [3:0]              cur_nib;
   logic [NUM_DIGITS-1:0]   sel_nxt;

   scan_prescaler #(.PRESCALE(PRESCALE)) u_prescaler (
      .clk       (clk),
      .rst       (rst),
      .pcnt_zero (pcnt_zero),
      .wrap      (wrap)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst)           shadow <= '0;
      else if (bus.load) shadow <= bus.value;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)       idx <= '0;
      else if (wrap) idx <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
   end

`ifdef HEX_SCAN_LZB_EN
   // significant[k] is set when any nibble at position k or above is non-zero.
   logic [NUM_DIGITS:0] significant;

   // NOTE: combinational blocks assign every output a default first so no latch is inferred.
   always_comb begin
      significant             = '0;
      for (int k = NUM_DIGITS - 1; k >= 0; k--) begin
         significant[k] = significant[k+1] | (shadow[4*k +: 4] != 4'h0);
      end
      digit_ok = (idx == '0) || significant[idx];
   end
`else
   assign digit_ok = 1'b1;
`endif

   always_comb begin
      cur_nib = shadow[4*idx +: 4];
      show    = bus.display_on && !pcnt_zero && digit_ok;
      sel_nxt = SEL_OFF[NUM_DIGITS-1:0];
      if (show) sel_nxt = ~(NUM_DIGITS'(1) << idx);
   end

   // Outputs are registered so the decoder and digit drivers see glitch-free levels.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.binary      <= RST_BINARY;
         bus.enable      <= RST_ENABLE;
         bus.digit_sel_n <= SEL_OFF[NUM_DIGITS-1:0];
         bus.scan_tick   <= RST_SCAN_TICK;
      end else begin
         bus.binary      <= show ? cur_nib : BLANK_NIBBLE;
         bus.enable      <= show;
         bus.digit_sel_n <= sel_nxt;
         bus.scan_tick   <= pcnt_zero;
      end
   end

endmodule

// File: tb/tb_hex_digit_scan.sv
// Directed, table-driven bench for hex_digit_scan (PRESCALE=4 table plus a PRESCALE=2 sequence).
module tb_hex_digit_scan;

   typedef struct {
      logic        rst;
      logic        load;
      logic [15:0] value;
      logic        don;
      logic [3:0]  sel;
      logic [3:0]  bin;
      logic        en;
      logic        tick;
   } vec_t;

   logic clk  = 1'b0;
   logic rst  = 1'b1;
   logic rst2 = 1'b1;

   int checks = 0;
   int errors = 0;

   vec_t tbl[$];

   always #5 clk = ~clk;

   hex_digit_scan_if #(.NUM_DIGITS(4)) bus4 ();
   hex_digit_scan_if #(.NUM_DIGITS(4)) bus2 ();

   hex_digit_scan #(.NUM_DIGITS(4), .PRESCALE(4)) dut4 (
      .clk (clk),
      .rst (rst),
      .bus (bus4)
   );

   hex_digit_scan #(.NUM_DIGITS(4), .PRESCALE(2)) dut2 (
      .clk (clk),
      .rst (rst2),
      .bus (bus2)
   );

   task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic check4(input string tag, input logic [3:0] sel, input logic [3:0] bin,
                         input logic en, input logic tick);
      check({tag, ".sel"},  16'(bus4.digit_sel_n), 16'(sel));
      check({tag, ".bin"},  16'(bus4.binary),      16'(bin));
      check({tag, ".en"},   16'(bus4.enable),      16'(en));
      check({tag, ".tick"}, 16'(bus4.scan_tick),   16'(tick));
   endtask

   task automatic check2(input string tag, input logic [3:0] sel, input logic [3:0] bin,
                         input logic en, input logic tick);
      check({tag, ".sel"},  16'(bus2.digit_sel_n), 16'(sel));
      check({tag, ".bin"},  16'(bus2.binary),      16'(bin));
      check({tag, ".en"},   16'(bus2.enable),      16'(en));
      check({tag, ".tick"}, 16'(bus2.scan_tick),   16'(tick));
   endtask

   function automatic void row(logic r, logic ld, logic [15:0] v, logic don,
                               logic [3:0] sel, logic [3:0] bin, logic en, logic tick);
      vec_t x;
      x.rst = r; x.load = ld; x.value = v; x.don = don;
      x.sel = sel; x.bin = bin; x.en = en; x.tick = tick;
      tbl.push_back(x);
   endfunction

   function automatic void rst_row();
      row(1'b1, 1'b0, 16'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
   endfunction

   function automatic void guard();
      row(1'b0, 1'b0, 16'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1);
   endfunction

   function automatic void lit(logic [3:0] sel, logic [3:0] bin);
      row(1'b0, 1'b0, 16'h0, 1'b1, sel, bin, 1'b1, 1'b0);
   endfunction

   function automatic void lit3(logic [3:0] sel, logic [3:0] bin);
      for (int i = 0; i < 3; i++) lit(sel, bin);
   endfunction

   function automatic void dwell(logic [3:0] sel, logic [3:0] bin, logic on);
      guard();
      for (int i = 0; i < 3; i++) begin
         if (on) lit(sel, bin);
         else    row(1'b0, 1'b0, 16'h0, 1'b1, 4'hF, 4'h0, 1'b0, 1'b0);
      end
   endfunction

   initial begin
      int a_end;
      logic [3:0] s2 [12];
      logic [3:0] b2 [12];

      bus4.value = '0; bus4.load = 1'b0; bus4.display_on = 1'b1;
      bus2.value = '0; bus2.load = 1'b0; bus2.display_on = 1'b1;

      // Segment A: basic scan of 1A3F, mid-dwell load, display_on gap.
      rst_row();
      row(1'b0, 1'b1, 16'h1A3F, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1);
      lit3(4'b1110, 4'hF);
      dwell(4'b1101, 4'h3, 1'b1);
      dwell(4'b1011, 4'hA, 1'b1);
      dwell(4'b0111, 4'h1, 1'b1);
      dwell(4'b1110, 4'hF, 1'b1);
      dwell(4'b1101, 4'h3, 1'b1);
      guard();
      lit(4'b1011, 4'hA);
      row(1'b0, 1'b1, 16'h5555, 1'b1, 4'b1011, 4'hA, 1'b1, 1'b0);
      lit(4'b1011, 4'h5);
      dwell(4'b0111, 4'h5, 1'b1);
      dwell(4'b1110, 4'h5, 1'b1);
      for (int i = 0; i < 10; i++)
         row(1'b0, 1'b0, 16'h0, 1'b0, 4'hF, 4'h0, 1'b0, (i % 4) == 0);
      lit(4'b0111, 4'h5);
      lit(4'b0111, 4'h5);
      guard();
      lit(4'b1110, 4'h5);
      a_end = tbl.size();

      // Segment B: 0042 after reset.
      rst_row();
      row(1'b0, 1'b1, 16'h0042, 1'b1, 4'hF, 4'h0, 1'b0, 1'b1);
      lit3(4'b1110, 4'h2);
      dwell(4'b1101, 4'h4, 1'b1);
`ifdef HEX_SCAN_LZB_EN
      dwell(4'b1011, 4'h0, 1'b0);
      dwell(4'b0111, 4'h0, 1'b0);
`else
      dwell(4'b1011, 4'h0, 1'b1);
      dwell(4'b0111, 4'h0, 1'b1);
`endif

      // Segment C: shadow cleared by reset, value 0000.
      rst_row();
      guard();
      lit3(4'b1110, 4'h0);
`ifdef HEX_SCAN_LZB_EN
      dwell(4'b1101, 4'h0, 1'b0);
      dwell(4'b1011, 4'h0, 1'b0);
      dwell(4'b0111, 4'h0, 1'b0);
`else
      dwell(4'b1101, 4'h0, 1'b1);
      dwell(4'b1011, 4'h0, 1'b1);
      dwell(4'b0111, 4'h0, 1'b1);
`endif

      for (int i = 0; i < tbl.size(); i++) begin
         if (i == a_end) begin
            // Asynchronous reset mid-cycle while digit 0 is lit.
            rst = 1'b1;
            #1;
            check4("async_rst", 4'hF, 4'h0, 1'b0, 1'b0);
         end
         rst             = tbl[i].rst;
         bus4.load       = tbl[i].load;
         bus4.value      = tbl[i].value;
         bus4.display_on = tbl[i].don;
         @(posedge clk);
         @(negedge clk);
         check4($sformatf("row%0d", i), tbl[i].sel, tbl[i].bin, tbl[i].en, tbl[i].tick);
      end

      // PRESCALE=2: guard and lit alternate every cycle, idx wraps 3 -> 0.
      check2("p2_reset", 4'hF, 4'h0, 1'b0, 1'b0);
      s2 = '{4'hF, 4'b1110, 4'hF, 4'b1101, 4'hF, 4'b1011, 4'hF, 4'b0111, 4'hF, 4'b1110, 4'hF, 4'b1101};
      b2 = '{4'h0, 4'hF,    4'h0, 4'h3,    4'h0, 4'hA,    4'h0, 4'h1,    4'h0, 4'hF,    4'h0, 4'h3};
      rst2 = 1'b0;
      bus2.value = 16'h1A3F;
      for (int i = 0; i < 12; i++) begin
         bus2.load = (i == 0);
         @(posedge clk);
         @(negedge clk);
         check2($sformatf("p2_%0d", i), s2[i], b2[i], (i % 2) == 1, (i % 2) == 0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
